// File: rtl/sm3_arb_pkg.sv
// Shared types and widths for the SM3 message arbiter: FSM encoding, bus widths
// and the channel-id width helper.
package sm3_arb_pkg;

    localparam int DATA_W   = 64;
    localparam int KEEP_W   = 8;
    localparam int DIGEST_W = 256;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_STREAM = 4'b0010,
        ST_WAIT   = 4'b0100,
        ST_DONE   = 4'b1000
    } state_e;

    // Never narrower than one bit, so a 2-channel build still has an id.
    function automatic int CH_ID_W(input int n_ch);
        return (n_ch > 2) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel strictly after
// last_gnt_i, wrapping modulo N_CH.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] last_gnt_i,
    output logic [CH_W-1:0] gnt_id_o,
    output logic            any_req_o
);

    logic [CH_W-1:0] cand;

    // Walk from farthest to nearest so the nearest requester wins the last write.
    always_comb begin
        gnt_id_o = '0;
        cand     = '0;
        for (int k = N_CH; k >= 1; k--) begin
            cand = CH_W'((int'(last_gnt_i) + k) % N_CH);
            if (req_i[cand]) begin
                gnt_id_o = cand;
            end
        end
        any_req_o = |req_i;
    end

endmodule

// File: rtl/sm3_msg_arbiter.sv
// Message-level round-robin scheduler sharing one SM3 core among N_CH streams;
// returns each digest tagged with the channel that produced its message.
module sm3_msg_arbiter
    import sm3_arb_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CH*DATA_W-1:0]      ch_data_i,
    input  logic [N_CH*KEEP_W-1:0]      ch_keep_i,
    input  logic [N_CH-1:0]             ch_valid_i,
    input  logic [N_CH-1:0]             ch_last_i,
    output logic [N_CH-1:0]             ch_ready_o,
    output logic [DATA_W-1:0]           core_data_o,
    output logic [KEEP_W-1:0]           core_keep_o,
    output logic                        core_valid_o,
    output logic                        core_last_o,
    input  logic                        core_ready_i,
    input  logic                        core_dout_valid_i,
    input  logic [DIGEST_W-1:0]         core_dout_i,
    output logic [DIGEST_W-1:0]         digest_o,
    output logic [CH_ID_W(N_CH)-1:0]    digest_ch_o,
    output logic                        digest_valid_o,
    input  logic                        digest_ready_i,
    output logic                        busy_o,
    output logic                        err_timeout_o,
    output logic                        err_spurious_o
);

    localparam int              CH_W     = CH_ID_W(N_CH);
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CH_W-1:0]  GNT_RST  = CH_W'(N_CH - 1);

    logic [DATA_W-1:0] ch_data [N_CH];
    logic [KEEP_W-1:0] ch_keep [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign ch_data[gi] = ch_data_i[gi*DATA_W +: DATA_W];
            assign ch_keep[gi] = ch_keep_i[gi*KEEP_W +: KEEP_W];
        end
    endgenerate

    state_e              state_q, state_d;
    logic [CH_W-1:0]     gnt_q, gnt_d;
    logic [CH_W-1:0]     last_gnt_q, last_gnt_d;
    logic [CH_W-1:0]     digest_ch_q, digest_ch_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic [CNT_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic                err_timeout_q, err_timeout_d;
    logic                err_spurious_q, err_spurious_d;
    logic [CH_W-1:0]     pick_id;
    logic                any_req;
    logic                xfer;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr (
        .req_i      (ch_valid_i),
        .last_gnt_i (last_gnt_q),
        .gnt_id_o   (pick_id),
        .any_req_o  (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            gnt_q          <= '0;
            last_gnt_q     <= GNT_RST;
            digest_ch_q    <= '0;
            digest_q       <= '0;
            wd_cnt_q       <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            last_gnt_q     <= last_gnt_d;
            digest_ch_q    <= digest_ch_d;
            digest_q       <= digest_d;
            wd_cnt_q       <= wd_cnt_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_gnt_d     = last_gnt_q;
        digest_ch_d    = digest_ch_q;
        digest_d       = digest_q;
        wd_cnt_d       = wd_cnt_q;
        err_timeout_d  = 1'b0;
        err_spurious_d = core_dout_valid_i && (state_q != ST_WAIT);
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d   = pick_id;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer && ch_last_i[gnt_q]) begin
                    last_gnt_d = gnt_q;
                    wd_cnt_d   = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
                if (core_dout_valid_i) begin
                    digest_d    = core_dout_i;
                    digest_ch_d = gnt_q;
                    state_d     = ST_DONE;
                end else if (wd_cnt_q == CNT_LAST) begin
                    // The late digest, if any, is dropped; last_gnt already moved on.
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (digest_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        core_data_o  = '0;
        core_keep_o  = '0;
        core_valid_o = 1'b0;
        core_last_o  = 1'b0;
        ch_ready_o   = '0;
        xfer         = 1'b0;
        if (state_q == ST_STREAM) begin
            core_data_o       = ch_data[gnt_q];
            core_keep_o       = ch_keep[gnt_q];
            core_last_o       = ch_last_i[gnt_q];
            core_valid_o      = ch_valid_i[gnt_q];
            ch_ready_o[gnt_q] = core_ready_i;
            xfer              = ch_valid_i[gnt_q] && core_ready_i;
        end
    end

    assign digest_o       = digest_q;
    assign digest_ch_o    = digest_ch_q;
    assign digest_valid_o = (state_q == ST_DONE);
    assign busy_o         = (state_q != ST_IDLE);
    assign err_timeout_o  = err_timeout_q;
    assign err_spurious_o = err_spurious_q;

endmodule

// File: doc/sm3_msg_arbiter.md
# sm3_msg_arbiter

Message-level round-robin scheduler that shares one `sm3_top` hashing core among `N_CH` independent 64-bit byte-keep message streams. It sits in front of the core's `data_input_*` port. It grants a whole message (first beat to `last`) to one channel and holds that grant until the core returns the digest. It then presents the digest tagged with the originating channel id on a valid/ready result port.

## Interface
Parameters:
- `N_CH`, 4: number of requesting channels (2..16).
- `TIMEOUT_CYC`, 4096: maximum cycles in WAIT_DIGEST before abort.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ch_data_i` in N_CH*64: channel c occupies bits [c*64+63:c*64].
- `ch_keep_i` in N_CH*8: byte enables, channel c at [c*8+7:c*8].
- `ch_valid_i` in N_CH: beat valid per channel.
- `ch_last_i` in N_CH: last beat of message per channel.
- `ch_ready_o` out N_CH: beat accept per channel.
- `core_data_o` out 64: to core `data_input_i`.
- `core_keep_o` out 8: to core `data_input_keep_i`.
- `core_valid_o` out 1: to core `data_input_valid_i`.
- `core_last_o` out 1: to core `data_input_last_i`.
- `core_ready_i` in 1: core can take a beat (tie 1 if the core has no backpressure).
- `core_dout_valid_i` in 1: from core `sm3_output_valid_o`.
- `core_dout_i` in 256: from core `sm3_dout`.
- `digest_o` out 256: registered digest.
- `digest_ch_o` out clog2(N_CH): channel id of `digest_o`.
- `digest_valid_o` out 1: result valid.
- `digest_ready_i` in 1: result accepted.
- `busy_o` out 1: state != IDLE.
- `err_timeout_o` out 1: one-cycle pulse when the watchdog fires.
- `err_spurious_o` out 1: one-cycle pulse when `core_dout_valid_i` arrives outside WAIT_DIGEST.

## Operation
- FSM states: IDLE, STREAM, WAIT_DIGEST, DONE. One-hot, 4 bits.
- IDLE:
  - If any `ch_valid_i` is set, select the first set channel strictly after `last_gnt` (wrapping modulo N_CH).
  - Register the selection into `gnt`, then go to STREAM.
  - All `ch_ready_o` are 0.
- STREAM: pass-through mux on `gnt`.
  - `core_data_o`, `core_keep_o`, `core_last_o` = `ch_*_i[gnt]`.
  - `core_valid_o` = `ch_valid_i[gnt]`.
  - `ch_ready_o[gnt]` = `core_ready_i`; all other ready bits are 0.
  - A beat transfers when valid & ready.
  - A transfer with `last` = 1 goes to WAIT_DIGEST and sets `last_gnt` <= `gnt`.
- WAIT_DIGEST:
  - `core_valid_o` = 0.
  - The watchdog counter clears on entry and increments each cycle.
  - On `core_dout_valid_i`: capture `core_dout_i` into `digest_o`, `gnt` into `digest_ch_o`, then go to DONE.
  - If the counter reaches `TIMEOUT_CYC - 1` with no digest: pulse `err_timeout_o` and go to IDLE, dropping the digest. `last_gnt` remains updated.
- DONE: `digest_valid_o` = 1 until `digest_ready_i`, then go to IDLE.
- When `digest_valid_o` = 1, the digest and channel registers stay stable until the handshake completes.
- `core_dout_valid_i` in IDLE, STREAM or DONE: ignore it and pulse `err_spurious_o`.
- A channel that drops `ch_valid_i` mid-message is not preempted; the grant is held until its `last`.
- Zero-keep beats are forwarded unchanged; keep semantics belong to the core.

## Timing
- Reset values:
  - State IDLE, `gnt` = 0, `last_gnt` = N_CH-1 (so channel 0 has first priority).
  - All outputs 0, including `digest_o`, `digest_ch_o` and both error pulses.
- Arbitration latency: valid seen in IDLE at cycle t; the first beat can transfer at t+1.
- Stream path: zero-latency combinational mux, 1 beat/cycle sustained.
- Digest latency: `digest_valid_o` rises the cycle after `core_dout_valid_i`.
- Turnaround: the digest handshake at cycle t returns to IDLE at t+1; the next grant is at t+2 at the earliest.
- Reset mid-operation returns to IDLE immediately. The core must be reset together with the arbiter; a partial message is lost.

## Structure
- Shared package `sm3_arb_pkg`:
  - State encodings.
  - `DATA_W` = 64, `KEEP_W` = 8, `DIGEST_W` = 256.
  - `CH_ID_W` = clog2(N_CH) function.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req[N_CH]` and `last_gnt`, with outputs `gnt_id` and `any_req`. Instantiated once.
- The top-level holds the FSM, the mux, the watchdog and the result register.

## Test plan
- Single message:
  - Stimulus: ch0 sends 3 beats (last on beat 3, keep 8'hFF/FF/0F); core returns digest 256'hA5..A5 20 cycles later.
  - Required: `digest_valid_o`=1 with `digest_ch_o`=0 one cycle later; beats appear unchanged on `core_*`.
- Round robin:
  - Stimulus: all 4 channels hold valid continuously.
  - Required: grant order 0,1,2,3,0; each digest tagged with the matching channel.
- Backpressure:
  - Stimulus: `core_ready_i` toggles 1,0,1,0 during ch2's 4-beat message.
  - Required: exactly 4 transfers, `ch_ready_o`=4'b0100 only on ready cycles, no duplicated beats.
- Result stall:
  - Stimulus: hold `digest_ready_i`=0 for 10 cycles.
  - Required: `digest_o`/`digest_ch_o` stable, no new grant, `busy_o`=1.
- Timeout and spurious:
  - Stimulus (timeout): `TIMEOUT_CYC`=16 and no core response. Required: `err_timeout_o` pulses 16 cycles after entering WAIT_DIGEST, then state IDLE.
  - Stimulus (spurious): `core_dout_valid_i` asserted in IDLE. Required: `err_spurious_o` pulse and no `digest_valid_o`.
- Reset mid-stream:
  - Stimulus: deassert `rst_n` during beat 2 of a message.
  - Required: all outputs 0 asynchronously; after release, channel 0 has priority.
